// File: rtl/xor_tree_frame_arbiter.sv
// Round-robin frame arbiter sharing one 16-input XOR reduction among NREQ requesters.
// Optional: define XOR_TREE_FRAME_ARB_MAXBEAT_EN to truncate frames at MAX_BEATS beats.
module xor_tree_frame_arbiter #(
   parameter int unsigned NREQ      = 4,
   parameter int unsigned MAX_BEATS = 16,
   localparam int unsigned IDW      = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ-1:0]      req_last,
   input  logic [16*NREQ-1:0]   req_data,
   output logic [NREQ-1:0]      req_ready,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic                 res_parity,
   output logic [IDW-1:0]       res_id,
   output logic                 res_err,
   output logic                 busy
);

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_RESP} state_t;

   state_t          state, state_nxt;
   logic [IDW-1:0]  ptr;
   logic [IDW-1:0]  grant;
   logic [IDW-1:0]  pick;
   logic [IDW-1:0]  idx;
   logic            found;
   logic            accept;
   logic            beat_par;
   logic            trunc;
   logic            acc;
   logic [4:0]      beat_cnt;
   logic [15:0]     data_arr [NREQ];

   if (NREQ < 2 || NREQ > 8 || MAX_BEATS < 2) begin : g_param_check
      $error("xor_tree_frame_arbiter: NREQ must be 2..8 and MAX_BEATS >= 2");
   end

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign data_arr[g] = req_data[16*g +: 16];
   end

   assign beat_par = ^data_arr[grant];

`ifdef XOR_TREE_FRAME_ARB_MAXBEAT_EN
   // High when the beat being offered would be beat number MAX_BEATS of the frame.
   assign trunc = (({27'd0, beat_cnt} + 32'd1) == MAX_BEATS);
`else
   assign trunc = 1'b0;
`endif

   // Pointer-ordered search: first valid requester at or above ptr, wrapping.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      idx   = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         idx = IDW'((ptr + i) % NREQ);
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      req_ready = '0;
      res_valid = 1'b0;
      accept    = 1'b0;
      busy      = (state != S_IDLE);
      case (state)
         S_IDLE: begin
            if (found) state_nxt = S_ACCUM;
         end
         S_ACCUM: begin
            req_ready[grant] = 1'b1;
            accept           = req_valid[grant];
            if (accept && (req_last[grant] || trunc)) state_nxt = S_RESP;
         end
         S_RESP: begin
            res_valid = 1'b1;
            if (res_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         ptr        <= '0;
         grant      <= '0;
         acc        <= 1'b0;
         beat_cnt   <= '0;
         res_parity <= 1'b0;
         res_id     <= '0;
         res_err    <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE: begin
               if (found) begin
                  grant    <= pick;
                  ptr      <= (pick == IDW'(NREQ - 1)) ? '0 : pick + 1'b1;
                  acc      <= 1'b0;
                  beat_cnt <= '0;
               end
            end
            S_ACCUM: begin
               if (accept) begin
                  acc <= acc ^ beat_par;
                  if (beat_cnt != '1) beat_cnt <= beat_cnt + 5'd1;
                  if (req_last[grant] || trunc) begin
                     res_parity <= acc ^ beat_par;
                     res_id     <= grant;
                     res_err    <= trunc & ~req_last[grant];
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_xor_tree_frame_arbiter.sv
// Scoreboard bench for xor_tree_frame_arbiter: frame-level round-robin/parity model.
module tb_xor_tree_frame_arbiter;

   localparam int NR           = 4;
   localparam int TB_MAX_BEATS = 4;
`ifdef XOR_TREE_FRAME_ARB_MAXBEAT_EN
   localparam bit TRUNC_EN = 1'b1;
`else
   localparam bit TRUNC_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [NR-1:0]   req_valid = '0;
   logic [NR-1:0]   req_last = '0;
   logic [16*NR-1:0] req_data = '0;
   logic [NR-1:0]   req_ready;
   logic            res_valid;
   logic            res_ready;
   logic            res_parity;
   logic [1:0]      res_id;
   logic            res_err;
   logic            busy;

   typedef struct packed {
      logic [2:0]  r;
      logic [15:0] d;
      logic        last;
      logic [3:0]  gap;
   } beat_t;

   typedef struct packed {
      logic [1:0] id;
      logic       par;
      logic       err;
   } exp_t;

   beat_t stage[$];
   beat_t pend[$];
   exp_t  sb[$];
   int    rr_ptr = 0;
   int    n_tests = 0;
   int    n_fail = 0;
   int    rdy_mode = 0;
   int    gap_cnt[NR];
   bit    gap_loaded[NR];

   always #5 clk = ~clk;

   xor_tree_frame_arbiter #(.NREQ(NR), .MAX_BEATS(TB_MAX_BEATS)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
      .req_ready(req_ready),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_parity(res_parity), .res_id(res_id), .res_err(res_err),
      .busy(busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int head_idx(input int r);
      for (int i = 0; i < pend.size(); i++)
         if (int'(pend[i].r) == r) return i;
      return -1;
   endfunction

   task automatic push_beat(input int r, input logic [15:0] d, input bit last, input int gap);
      beat_t b;
      b.r = 3'(r); b.d = d; b.last = last; b.gap = 4'(gap);
      stage.push_back(b);
   endtask

   // Reference model: split frames into result chunks, then order them round-robin.
   task automatic commit();
      bit    par[NR];
      int    cnt[NR];
      exp_t  chunks[$];
      exp_t  e;
      beat_t b;
      bit    done;
      int    c;
      for (int r = 0; r < NR; r++) begin par[r] = 0; cnt[r] = 0; end
      for (int i = 0; i < stage.size(); i++) begin
         b = stage[i];
         if (cnt[b.r] == 0) b.gap = '0;
         par[b.r] = par[b.r] ^ bit'($countones(b.d) % 2);
         cnt[b.r]++;
         if (b.last || (TRUNC_EN && cnt[b.r] == TB_MAX_BEATS)) begin
            e.id = 2'(b.r); e.par = par[b.r]; e.err = !b.last;
            chunks.push_back(e);
            par[b.r] = 0; cnt[b.r] = 0;
         end
         pend.push_back(b);
      end
      stage.delete();
      while (chunks.size() > 0) begin
         done = 0;
         for (int k = 0; k < NR; k++) begin
            c = (rr_ptr + k) % NR;
            for (int j = 0; j < chunks.size() && !done; j++) begin
               if (int'(chunks[j].id) == c) begin
                  sb.push_back(chunks[j]);
                  chunks.delete(j);
                  rr_ptr = (c + 1) % NR;
                  done = 1;
               end
            end
            if (done) break;
         end
      end
   endtask

   task automatic apply_drive();
      int h;
      for (int r = 0; r < NR; r++) begin
         h = head_idx(r);
         if (h < 0) begin
            req_valid[r] = 1'b0;
            req_last[r]  = 1'($urandom_range(0, 1));
            req_data[16*r +: 16] = 16'($urandom);
         end else begin
            if (!gap_loaded[r]) begin
               gap_cnt[r]    = int'(pend[h].gap);
               gap_loaded[r] = 1'b1;
            end
            if (gap_cnt[r] > 0) begin
               gap_cnt[r]--;
               req_valid[r] = 1'b0;
               req_data[16*r +: 16] = 16'($urandom);
            end else begin
               req_valid[r] = 1'b1;
               req_last[r]  = pend[h].last;
               req_data[16*r +: 16] = pend[h].d;
            end
         end
      end
   endtask

   task automatic drive_cycle();
      logic [NR-1:0] acc;
      int h;
      apply_drive();
      @(negedge clk);
      acc = req_ready & req_valid;
      @(posedge clk); #1;
      for (int r = 0; r < NR; r++) begin
         if (acc[r]) begin
            h = head_idx(r);
            if (h >= 0) pend.delete(h);
            gap_loaded[r] = 1'b0;
         end
      end
   endtask

   task automatic run_batch(input string name, input int bound);
      int cyc = 0;
      while ((pend.size() > 0 || sb.size() > 0) && cyc < bound) begin
         drive_cycle();
         cyc++;
      end
      chk(name, (pend.size() == 0 && sb.size() == 0), 1);
      pend.delete();
      sb.delete();
   endtask

   task automatic clear_model();
      pend.delete(); sb.delete(); stage.delete();
      rr_ptr = 0;
      for (int r = 0; r < NR; r++) gap_loaded[r] = 1'b0;
   endtask

   task automatic do_reset(input string name);
      rst = 1'b1;
      req_valid = '0; req_last = '0; req_data = '0;
      repeat (2) @(posedge clk);
      #1;
      chk(name, {req_ready, res_valid, res_parity, res_id, res_err, busy}, 0);
      rst = 1'b0;
      clear_model();
   endtask

   // Monitor: owns res_ready, pops the scoreboard on each result handshake.
   initial begin
      bit   held = 0;
      logic [3:0] saved = '0;
      exp_t e;
      res_ready = 1'b1;
      forever begin
         @(negedge clk);
         case (rdy_mode)
            0: res_ready = 1'b1;
            1: res_ready = 1'($urandom_range(0, 1));
            default: res_ready = 1'b0;
         endcase
         chk("ready_onehot", ($countones(req_ready) <= 1), 1);
         if (rst) begin
            held = 0;
         end else if (res_valid) begin
            chk("resp_no_ready", req_ready, 0);
            if (held) chk("resp_stable", {res_parity, res_id, res_err}, saved);
            if (res_ready) begin
               if (sb.size() == 0) begin
                  chk("unexpected_result", 1, 0);
               end else begin
                  e = sb.pop_front();
                  chk("result", {res_id, res_parity, res_err}, {e.id, e.par, e.err});
               end
               held = 0;
            end else begin
               held  = 1;
               saved = {res_parity, res_id, res_err};
            end
         end else begin
            held = 0;
         end
      end
   end

   initial begin
      int nf, nb, c;
      logic [3:0] cap;

      do_reset("reset_outputs");

      // Single one-beat frame: grant, beat, one RESP cycle.
      push_beat(0, 16'h0001, 1, 0);
      commit();
      drive_cycle();
      chk("t1_grant", {busy, req_ready}, 5'b1_0001);
      drive_cycle();
      chk("t1_resp", res_valid, 1);
      drive_cycle();
      chk("t1_idle", {res_valid, busy}, 0);
      run_batch("t1_done", 10);

      // Gapped 3-beat frame from requester 2 while requester 0 waits.
      push_beat(2, 16'hFFFF, 0, 0);
      push_beat(2, 16'h0003, 0, 2);
      push_beat(2, 16'h0100, 1, 2);
      push_beat(0, 16'h00F1, 1, 0);
      commit();
      c = 0;
      while ((pend.size() > 0 || sb.size() > 0) && c < 40) begin
         drive_cycle();
         if (busy && !res_valid && head_idx(2) >= 0) chk("t2_lock", req_ready, 4'b0100);
         c++;
      end
      run_batch("t2_done", 1);

      // Full contention from reset: 0,1,2,3,0,1,2,3.
      do_reset("reset_outputs_2");
      for (int f = 0; f < 2; f++)
         for (int r = 0; r < NR; r++) push_beat(r, 16'($urandom), 1, 0);
      commit();
      run_batch("contend_done", 60);

      // Result back-pressure: hold res_ready low in RESP while another requester waits.
      rdy_mode = 2;
      push_beat(3, 16'h0007, 1, 0);
      commit();
      c = 0;
      while (!res_valid && c < 10) begin drive_cycle(); c++; end
      chk("stall_reached", res_valid, 1);
      cap = {res_parity, res_id, res_err};
      chk("stall_value", cap, {1'b1, 2'd3, 1'b0});
      push_beat(1, 16'h0001, 1, 0);
      commit();
      for (int k = 0; k < 5; k++) begin
         drive_cycle();
         chk("stall_hold", {res_valid, res_parity, res_id, res_err}, {1'b1, cap});
         chk("stall_no_ready", req_ready, 0);
      end
      rdy_mode = 0;
      drive_cycle();
      chk("stall_release", {res_valid, req_ready}, 0);
      run_batch("stall_done", 20);

      // Reset in the 3rd beat of a frame from requester 0; it then resends.
      req_valid = '0;
      req_valid[0] = 1'b1; req_last[0] = 1'b0; req_data[15:0] = 16'h1234;
      repeat (3) @(posedge clk);
      #1;
      req_data[15:0] = 16'h00FF;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midframe_reset", {req_ready, res_valid, res_parity, res_id, res_err, busy}, 0);
      rst = 1'b0;
      req_valid = '0;
      clear_model();
      push_beat(0, 16'h0003, 0, 0);
      push_beat(0, 16'h0010, 0, 1);
      push_beat(0, 16'h0000, 1, 0);
      push_beat(3, 16'h0101, 1, 0);
      commit();
      run_batch("resend_done", 40);

      // Six beats of 16'h0001, last only on beat 6 (truncation boundary when enabled).
      do_reset("reset_outputs_3");
      for (int k = 0; k < 6; k++) push_beat(0, 16'h0001, (k == 5), 0);
      commit();
      run_batch("long_frame_done", 40);

      // Randomized batches with gaps and result back-pressure.
      for (int b = 0; b < 8; b++) begin
         rdy_mode = (b % 2 == 1) ? 1 : 0;
         for (int r = 0; r < NR; r++) begin
            nf = $urandom_range(0, 2);
            for (int f = 0; f < nf; f++) begin
               nb = $urandom_range(1, TRUNC_EN ? 7 : 5);
               for (int k = 0; k < nb; k++)
                  push_beat(r, 16'($urandom), (k == nb - 1), $urandom_range(0, 2));
            end
         end
         commit();
         run_batch("random_batch_done", 800);
      end

      rdy_mode = 0;
      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
